block_feeder_4x4: RTL and testbench

BLOCK_FEEDER_4X4 -- requirements
Module: block_feeder_4x4

---
 rtl/dct_pkg.sv | 23 ++
 rtl/pix2fp.sv | 36 +++
 rtl/block_feeder_4x4.sv | 191 +++++++++++++++++++
 tb/tb_block_feeder_4x4.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared floating-point field widths and bank state encoding for the
// pixel-to-float block feeder.
package dct_pkg;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 24;
    localparam int FP_BIAS  = 127;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    function automatic logic [2:0] msb_pos(input logic [7:0] v);
        msb_pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                msb_pos = 3'(i);
            end
        end
    endfunction
endpackage

// File: rtl/pix2fp.sv
// Converts one 8-bit pixel (optionally level-shifted by 128) into an exact
// sign / biased exponent / explicit-one mantissa triple.
module pix2fp
    import dct_pkg::*;
#(
    parameter int LEVEL_SHIFT = 1
) (
    input  logic [7:0]          pix,
    output logic                sgn,
    output logic [FP_EXP_W-1:0] exp_o,
    output logic [FP_MAN_W-1:0] man
);
    logic [8:0] v_s;
    logic [7:0] mag_s;
    logic [2:0] k_s;

    // Level shift, magnitude, and normalisation by the magnitude's top set bit.
    always_comb begin
        if (LEVEL_SHIFT != 0) begin
            v_s = {1'b0, pix} - 9'd128;
        end else begin
            v_s = {1'b0, pix};
        end
        mag_s = v_s[8] ? 8'(9'd0 - v_s) : v_s[7:0];
        k_s   = msb_pos(mag_s);
        if (mag_s == 8'd0) begin
            sgn   = 1'b0;
            exp_o = 8'd0;
            man   = 24'd0;
        end else begin
            sgn   = v_s[8];
            exp_o = 8'(FP_BIAS) + {5'd0, k_s};
            man   = {16'd0, mag_s} << (5'd23 - {2'd0, k_s});
        end
    end
endmodule

// File: rtl/block_feeder_4x4.sv
// Ping-pong buffered 4x4 pixel block feeder: fills one 16-pixel bank while the
// other is issued as four registered rows of floats on consecutive cycles.
module block_feeder_4x4
    import dct_pkg::*;
#(
    parameter int LEVEL_SHIFT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        x0s,
    output logic        x1s,
    output logic        x2s,
    output logic        x3s,
    output logic [7:0]  x0e,
    output logic [7:0]  x1e,
    output logic [7:0]  x2e,
    output logic [7:0]  x3e,
    output logic [23:0] x0,
    output logic [23:0] x1,
    output logic [23:0] x2,
    output logic [23:0] x3,
    output logic        out_valid,
    output logic [1:0]  row_idx,
    output logic        blk_start
);
    logic [7:0]  mem_q [2][16];
    logic [7:0]  mem_d [2][16];
    bank_state_e state_q [2];
    bank_state_e state_d [2];
    logic        fill_bank_q, fill_bank_d;
    logic [3:0]  fill_ptr_q, fill_ptr_d;
    logic        pix_ready_q, pix_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  row_q, row_d;
    logic        drain_bank_q, drain_bank_d;
    logic        blk_start_q, blk_start_d;
    logic [3:0]  xs_q, xs_d;
    logic [7:0]  xe_q [4];
    logic [7:0]  xe_d [4];
    logic [23:0] xm_q [4];
    logic [23:0] xm_d [4];

    logic        accept_s, complete_s, last_row_s, start_s, has_cand_s, cand_s;
    logic [3:0]  cs_s;
    logic [7:0]  ce_s [4];
    logic [23:0] cm_s [4];

    // Handshake, drain sequencing, and per-bank state transitions.
    always_comb begin
        accept_s   = pix_valid && pix_ready_q;
        complete_s = accept_s && (fill_ptr_q == 4'd15);
        last_row_s = out_valid_q && (row_q == 2'd3);
        // A completing fill bank can never coexist with a FULL bank: ready would be low.
        if (state_q[0] == FULL) begin
            has_cand_s = 1'b1;
            cand_s     = 1'b0;
        end else if (state_q[1] == FULL) begin
            has_cand_s = 1'b1;
            cand_s     = 1'b1;
        end else if (complete_s) begin
            has_cand_s = 1'b1;
            cand_s     = fill_bank_q;
        end else begin
            has_cand_s = 1'b0;
            cand_s     = 1'b0;
        end
        start_s = has_cand_s && (!out_valid_q || last_row_s);

        if (out_valid_q && !last_row_s) begin
            out_valid_d  = 1'b1;
            row_d        = row_q + 2'd1;
            drain_bank_d = drain_bank_q;
            blk_start_d  = 1'b0;
        end else if (start_s) begin
            out_valid_d  = 1'b1;
            row_d        = 2'd0;
            drain_bank_d = cand_s;
            blk_start_d  = 1'b1;
        end else begin
            out_valid_d  = 1'b0;
            row_d        = 2'd0;
            drain_bank_d = drain_bank_q;
            blk_start_d  = 1'b0;
        end

        fill_ptr_d  = accept_s ? fill_ptr_q + 4'd1 : fill_ptr_q;
        fill_bank_d = complete_s ? ~fill_bank_q : fill_bank_q;
        mem_d       = mem_q;
        if (accept_s) begin
            mem_d[fill_bank_q][fill_ptr_q] = pix_in;
        end else begin
            mem_d[fill_bank_q][fill_ptr_q] = mem_q[fill_bank_q][fill_ptr_q];
        end

        for (int b = 0; b < 2; b++) begin
            if (start_s && (cand_s == 1'(b))) begin
                state_d[b] = DRAINING;
            end else if (last_row_s && (drain_bank_q == 1'(b))) begin
                state_d[b] = EMPTY;
            end else if (accept_s && (fill_bank_q == 1'(b))) begin
                state_d[b] = complete_s ? FULL : FILLING;
            end else begin
                state_d[b] = state_q[b];
            end
        end
        pix_ready_d = (state_d[fill_bank_d] == EMPTY) || (state_d[fill_bank_d] == FILLING);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] row_pix_s;
        assign row_pix_s = mem_q[drain_bank_d][{row_d, 2'(c)}];
        pix2fp #(.LEVEL_SHIFT(LEVEL_SHIFT)) u_pix2fp (
            .pix   (row_pix_s),
            .sgn   (cs_s[c]),
            .exp_o (ce_s[c]),
            .man   (cm_s[c])
        );
    end

    // Row data is forced to zero whenever no row is being issued.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            if (out_valid_d) begin
                xs_d[c] = cs_s[c];
                xe_d[c] = ce_s[c];
                xm_d[c] = cm_s[c];
            end else begin
                xs_d[c] = 1'b0;
                xe_d[c] = 8'd0;
                xm_d[c] = 24'd0;
            end
        end
    end

    // State, bank storage and registered row outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= EMPTY;
                for (int i = 0; i < 16; i++) begin
                    mem_q[b][i] <= 8'd0;
                end
            end
            fill_bank_q  <= 1'b0;
            fill_ptr_q   <= 4'd0;
            pix_ready_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            row_q        <= 2'd0;
            drain_bank_q <= 1'b0;
            blk_start_q  <= 1'b0;
            xs_q         <= 4'd0;
            for (int c = 0; c < 4; c++) begin
                xe_q[c] <= 8'd0;
                xm_q[c] <= 24'd0;
            end
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            fill_bank_q  <= fill_bank_d;
            fill_ptr_q   <= fill_ptr_d;
            pix_ready_q  <= pix_ready_d;
            out_valid_q  <= out_valid_d;
            row_q        <= row_d;
            drain_bank_q <= drain_bank_d;
            blk_start_q  <= blk_start_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            xm_q         <= xm_d;
        end
    end

    assign pix_ready = pix_ready_q;
    assign out_valid = out_valid_q;
    assign row_idx   = row_q;
    assign blk_start = blk_start_q;
    assign x0s = xs_q[0];
    assign x1s = xs_q[1];
    assign x2s = xs_q[2];
    assign x3s = xs_q[3];
    assign x0e = xe_q[0];
    assign x1e = xe_q[1];
    assign x2e = xe_q[2];
    assign x3e = xe_q[3];
    assign x0  = xm_q[0];
    assign x1  = xm_q[1];
    assign x2  = xm_q[2];
    assign x3  = xm_q[3];
endmodule

// File: tb/tb_block_feeder_4x4.sv
// Scoreboard bench: a predictor turns accepted pixels into expected rows with
// their issue cycles; a monitor compares every output cycle against them.
module tb_block_feeder_4x4;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pix_in = 8'd0;
    logic       pix_valid = 1'b0;

    logic        rdy1, ov1, bs1, rdy0, ov0, bs0;
    logic [1:0]  ri1, ri0;
    logic [3:0]  s1, s0;
    logic [7:0]  e1 [4];
    logic [7:0]  e0 [4];
    logic [23:0] m1 [4];
    logic [23:0] m0 [4];
    logic [31:0] e1p, e0p;
    logic [95:0] m1p, m0p;

    assign e1p = {e1[3], e1[2], e1[1], e1[0]};
    assign e0p = {e0[3], e0[2], e0[1], e0[0]};
    assign m1p = {m1[3], m1[2], m1[1], m1[0]};
    assign m0p = {m0[3], m0[2], m0[1], m0[0]};

    block_feeder_4x4 #(.LEVEL_SHIFT(1)) dut1 (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy1),
        .x0s(s1[0]), .x1s(s1[1]), .x2s(s1[2]), .x3s(s1[3]),
        .x0e(e1[0]), .x1e(e1[1]), .x2e(e1[2]), .x3e(e1[3]),
        .x0(m1[0]), .x1(m1[1]), .x2(m1[2]), .x3(m1[3]),
        .out_valid(ov1), .row_idx(ri1), .blk_start(bs1)
    );

    block_feeder_4x4 #(.LEVEL_SHIFT(0)) dut0 (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy0),
        .x0s(s0[0]), .x1s(s0[1]), .x2s(s0[2]), .x3s(s0[3]),
        .x0e(e0[0]), .x1e(e0[1]), .x2e(e0[2]), .x3e(e0[3]),
        .x0(m0[0]), .x1(m0[1]), .x2(m0[2]), .x3(m0[3]),
        .out_valid(ov0), .row_idx(ri0), .blk_start(bs0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          cyc;
        int          row;
        logic [3:0]  s1;
        logic [31:0] e1;
        logic [95:0] m1;
        logic [3:0]  s0;
        logic [31:0] e0;
        logic [95:0] m0;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         since_rst = 0;
    int         last_start = -100;
    logic [7:0] pix_q [$];
    exp_t       exp_q [$];
    int         blk_e [$];
    int         blk_s [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) since_rst <= 0;
        else        since_rst <= since_rst + 1;
    end

    task automatic chk(input bit ok, input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference conversion: returns {sign, exponent, mantissa}.
    function automatic logic [32:0] ref_fp(input int p, input int ls);
        int v, mag, k;
        logic s;
        logic [7:0] e;
        logic [23:0] m;
        v = (ls != 0) ? p - 128 : p;
        s = (v < 0);
        mag = s ? -v : v;
        if (mag == 0) return 33'd0;
        k = 0;
        while ((1 << (k + 1)) <= mag) k++;
        e = 8'(127 + k);
        m = 24'(mag * (1 << (23 - k)));
        return {s, e, m};
    endfunction

    // Predictor: every 16 accepted pixels become four expected rows.
    always @(negedge clk) begin : predictor
        int e_cyc, st;
        exp_t x;
        logic [32:0] f;
        if (reset && pix_valid && rdy1) begin
            pix_q.push_back(pix_in);
            if (pix_q.size() == 16) begin
                e_cyc = cyc + 1;
                st = (e_cyc > last_start + 4) ? e_cyc : last_start + 4;
                last_start = st;
                blk_e.push_back(e_cyc);
                blk_s.push_back(st);
                for (int r = 0; r < 4; r++) begin
                    x = '0;
                    x.cyc = st + r;
                    x.row = r;
                    for (int c = 0; c < 4; c++) begin
                        f = ref_fp(int'(pix_q[4*r+c]), 1);
                        x.s1[c] = f[32];
                        x.e1[8*c +: 8] = f[31:24];
                        x.m1[24*c +: 24] = f[23:0];
                        f = ref_fp(int'(pix_q[4*r+c]), 0);
                        x.s0[c] = f[32];
                        x.e0[8*c +: 8] = f[31:24];
                        x.m0[24*c +: 24] = f[23:0];
                    end
                    exp_q.push_back(x);
                end
                pix_q.delete();
            end
        end
    end

    // Monitor: ready versus free-bank count, and every output row.
    always @(negedge clk) begin : monitor
        exp_t x;
        int occ;
        if (reset) begin
            if (since_rst >= 1) begin
                occ = 0;
                foreach (blk_e[i]) if (blk_e[i] <= cyc && cyc <= blk_s[i] + 3) occ++;
                chk(rdy1 == (occ < 2) && rdy0 == rdy1, "pix_ready", {rdy1, rdy0}, (occ < 2) ? 2'b11 : 2'b00);
            end
            if (ov1) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_row", {ri1, cyc}, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk(cyc == x.cyc && ov0, "row_timing", {ov0, cyc}, {1'b1, x.cyc});
                    chk(ri1 == 2'(x.row) && ri0 == 2'(x.row), "row_idx", {ri1, ri0}, {2'(x.row), 2'(x.row)});
                    chk(bs1 == (x.row == 0) && bs0 == bs1, "blk_start", {bs1, bs0}, {2{x.row == 0}});
                    chk({s1, e1p, m1p} == {x.s1, x.e1, x.m1}, "data_ls1", {s1, e1p, m1p}, {x.s1, x.e1, x.m1});
                    chk({s0, e0p, m0p} == {x.s0, x.e0, x.m0}, "data_ls0", {s0, e0p, m0p}, {x.s0, x.e0, x.m0});
                end
            end else begin
                chk(!ov0 && {s1, e1p, m1p, ri1, bs1, s0, e0p, m0p, ri0, bs0} == '0, "idle_zero",
                    {s1, e1p, m1p}, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    chk(1'b0, "missing_row", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        pix_valid = 1'b0;
        #1;
        chk(!ov1 && !ov0 && !rdy1 && !rdy0 &&
            {s1, e1p, m1p, ri1, bs1, s0, e0p, m0p, ri0, bs0} == '0, "reset_zero",
            {ov1, rdy1, s1, e1p, m1p}, 0);
        pix_q.delete();
        exp_q.delete();
        blk_e.delete();
        blk_s.delete();
        last_start = -100;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk(rdy1 && rdy0, "ready_after_reset", {rdy1, rdy0}, 2'b11);
    endtask

    task automatic send(input logic [7:0] p, output int waited);
        waited = 0;
        pix_valid = 1'b1;
        pix_in = p;
        @(negedge clk);
        while (!rdy1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) chk(1'b0, "send_timeout", waited, 0);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_block_random(input bit gaps);
        int w;
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), w);
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
    endtask

    initial begin
        int pat [4] = '{130, 132, 133, 135};
        int w, total_w, n;
        #1;
        do_reset();

        for (int i = 0; i < 16; i++) send(8'(pat[i % 4]), w);
        send(8'd128, w);
        send(8'd0, w);
        send(8'd255, w);
        for (int i = 0; i < 13; i++) send(8'($urandom_range(0, 255)), w);
        idle(8);

        total_w = 0;
        for (int i = 0; i < 48; i++) begin
            send(8'($urandom_range(0, 255)), w);
            total_w += w;
        end
        chk(total_w == 0, "stream_no_stall", total_w, 0);
        idle(6);

        for (int b = 0; b < 3; b++) send_block_random(1'b0);
        idle(3);

        for (int i = 0; i < 7; i++) send(8'($urandom_range(0, 255)), w);
        do_reset();
        send_block_random(1'b0);
        n = 0;
        while (!(ov1 && ri1 == 2'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(n < 100, "wait_row2", n, 0);
        #2;
        do_reset();
        send_block_random(1'b0);
        idle(6);

        for (int b = 0; b < 5; b++) send_block_random(1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
